// File: rtl/mult_issue_queue.sv
// Issue queue feeding a shared multiplier: buffers tagged requests,
// issues one at a time, and pairs each result with its destination tag.
module mult_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [15:0]              req_op1,
  input  logic [15:0]              req_op2,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     req_ready,
  input  logic                     flush,
  output logic [15:0]              mult_op1,
  output logic [15:0]              mult_op2,
  output logic                     mult_en,
  input  logic                     mult_free,
  input  logic                     mult_valid_wb,
  input  logic [15:0]              mult_out,
  output logic                     wb_valid,
  output logic [15:0]              wb_data,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0]      op1;
    logic [15:0]      op2;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DRAIN
  } state_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  state_t           state_q;
  logic             mult_en_q;
  logic [15:0]      op1_q, op2_q;
  logic [TAG_W-1:0] inflight_tag_q;
  logic             wb_valid_q;
  logic [15:0]      wb_data_q;
  logic [TAG_W-1:0] wb_tag_q;
  entry_t           head;
  logic             push, pop;

  assign req_ready = (count_q != FULL);
  assign head      = mem_q[rd_ptr_q];

  // flush wins over both push and pop
  assign push = req_valid && req_ready && !flush;
  assign pop  = (state_q == IDLE) && (count_q != '0)
             && mult_free && !flush;

  // Next-state of FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= '{op1: req_op1, op2: req_op2, tag: req_tag};
    end
  end

  // FIFO pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Issue/writeback sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mult_en_q      <= 1'b0;
      op1_q          <= '0;
      op2_q          <= '0;
      inflight_tag_q <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_tag_q       <= '0;
    end else begin
      mult_en_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            op1_q          <= head.op1;
            op2_q          <= head.op2;
            inflight_tag_q <= head.tag;
            mult_en_q      <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: state_q <= flush ? DRAIN : WAIT;
        WAIT: begin
          // a result landing with flush is simply dropped
          if (flush) begin
            state_q <= mult_valid_wb ? IDLE : DRAIN;
          end else if (mult_valid_wb) begin
            wb_data_q  <= mult_out;
            wb_tag_q   <= inflight_tag_q;
            wb_valid_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        DRAIN: if (mult_valid_wb) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mult_en  = mult_en_q;
  assign mult_op1 = op1_q;
  assign mult_op2 = op2_q;
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_tag   = wb_tag_q;
  assign count    = count_q;

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue: issue timing, backpressure,
// flush/drain, reset abandon, zero result and pointer wrap.
module tb_mult_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_op1, req_op2;
  logic [5:0]  req_tag;
  logic        req_ready;
  logic        flush;
  logic [15:0] mult_op1, mult_op2;
  logic        mult_en;
  logic        mult_free;
  logic        mult_valid_wb;
  logic [15:0] mult_out;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [5:0]  wb_tag;
  logic [2:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  mult_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op1(req_op1),
    .req_op2(req_op2), .req_tag(req_tag),
    .req_ready(req_ready), .flush(flush),
    .mult_op1(mult_op1), .mult_op2(mult_op2),
    .mult_en(mult_en), .mult_free(mult_free),
    .mult_valid_wb(mult_valid_wb), .mult_out(mult_out),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_tag(wb_tag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [15:0] a, input logic [15:0] b,
                          input logic [5:0] t);
    req_valid = 1'b1;
    req_op1 = a;
    req_op2 = b;
    req_tag = t;
    step();
    req_valid = 1'b0;
  endtask

  // Stimulus only: waits for an issue, returns what was seen,
  // answers with res and returns the writeback outputs.
  task automatic serve_op(input logic [15:0] res, output logic seen,
                          output logic [15:0] o1, output logic [15:0] o2,
                          output logic [2:0] cnt, output logic en2,
                          output logic wv, output logic [15:0] wd,
                          output logic [5:0] wt);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mult_en === 1'b1) seen = 1'b1;
      else step();
    end
    o1 = mult_op1;
    o2 = mult_op2;
    cnt = count;
    en2 = 1'b0;
    wv = 1'b0;
    wd = '0;
    wt = '0;
    if (seen) begin
      step();
      en2 = mult_en;
      mult_valid_wb = 1'b1;
      mult_out = res;
      step();
      mult_valid_wb = 1'b0;
      wv = wb_valid;
      wd = wb_data;
      wt = wb_tag;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if ({mult_en, wb_valid, req_ready, count} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: en/wbv/rdy/cnt got %b%b%b %0d want 001 0",
               mult_en, wb_valid, req_ready, count);
    end
    n_chk++;
    if ({mult_op1, mult_op2, wb_data, wb_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: op1 %h op2 %h wbd %h wbt %h want 0",
               mult_op1, mult_op2, wb_data, wb_tag);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    mult_free = 1'b1;
    push_req(16'd3, 16'd5, 6'd7);
    n_chk++;
    if (count !== 3'd1 || mult_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_push: cnt %0d en %b want 1 0", count, mult_en);
    end
    step();
    n_chk++;
    if (mult_en !== 1'b1 || mult_op1 !== 16'd3 || mult_op2 !== 16'd5) begin
      n_fail++;
      $display("FAIL basic_issue: en %b op %0d/%0d want 1 3/5",
               mult_en, mult_op1, mult_op2);
    end
    step();
    n_chk++;
    if (mult_en !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_wait: en %b cnt %0d want 0 0", mult_en, count);
    end
    mult_valid_wb = 1'b1;
    mult_out = 16'd15;
    step();
    mult_valid_wb = 1'b0;
    n_chk++;
    if (wb_valid !== 1'b1 || wb_data !== 16'd15 || wb_tag !== 6'd7) begin
      n_fail++;
      $display("FAIL basic_wb: v %b d %0d t %0d want 1 15 7",
               wb_valid, wb_data, wb_tag);
    end
    step();
    n_chk++;
    if (wb_valid !== 1'b0 || mult_op1 !== 16'd3) begin
      n_fail++;
      $display("FAIL basic_pulse: v %b op1 %0d want 0 3", wb_valid, mult_op1);
    end
  endtask

  task automatic test_back_to_back();
    logic seen, en2, wv;
    logic [15:0] o1, o2, wd;
    logic [5:0] wt;
    logic [2:0] cnt;
    mult_free = 1'b0;
    req_valid = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      req_op1 = 16'(t);
      req_op2 = 16'(t + 10);
      req_tag = 6'(t);
      if (t < 5) step();
    end
    step();
    n_chk++;
    if (count !== 3'd4 || req_ready !== 1'b0 || mult_en !== 1'b0) begin
      n_fail++;
      $display("FAIL full: cnt %0d rdy %b en %b want 4 0 0",
               count, req_ready, mult_en);
    end
    mult_free = 1'b1;
    step();
    n_chk++;
    if (count !== 3'd3 || mult_en !== 1'b1 || mult_op1 !== 16'd1) begin
      n_fail++;
      $display("FAIL full_pop: cnt %0d en %b op1 %0d want 3 1 1",
               count, mult_en, mult_op1);
    end
    step();
    req_valid = 1'b0;
    n_chk++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL held_push: cnt %0d want 4", count);
    end
    mult_valid_wb = 1'b1;
    mult_out = 16'd11;
    step();
    mult_valid_wb = 1'b0;
    n_chk++;
    if (wb_valid !== 1'b1 || wb_tag !== 6'd1 || wb_data !== 16'd11) begin
      n_fail++;
      $display("FAIL order_1: v %b t %0d d %0d want 1 1 11",
               wb_valid, wb_tag, wb_data);
    end
    for (int t = 2; t <= 5; t++) begin
      serve_op(16'(t * (t + 10)), seen, o1, o2, cnt, en2, wv, wd, wt);
      n_chk++;
      if (seen !== 1'b1 || o1 !== 16'(t) || cnt !== 3'(5 - t) || en2 !== 1'b0) begin
        n_fail++;
        $display("FAIL order_issue%0d: seen %b op1 %0d cnt %0d en2 %b",
                 t, seen, o1, cnt, en2);
      end
      n_chk++;
      if (wv !== 1'b1 || wt !== 6'(t) || wd !== 16'(t * (t + 10))) begin
        n_fail++;
        $display("FAIL order_wb%0d: v %b t %0d d %0d want 1 %0d %0d",
                 t, wv, wt, wd, t, t * (t + 10));
      end
    end
  endtask

  task automatic test_flush();
    logic seen, en2, wv;
    logic [15:0] o1, o2, wd;
    logic [5:0] wt;
    logic [2:0] cnt;
    push_req(16'd1, 16'd2, 6'd20);
    push_req(16'd3, 16'd4, 6'd21);
    push_req(16'd5, 16'd6, 6'd22);
    n_chk++;
    if (count !== 3'd2 || mult_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pre: cnt %0d en %b want 2 0", count, mult_en);
    end
    flush = 1'b1;
    req_valid = 1'b1;
    req_tag = 6'd23;
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    n_chk++;
    if (count !== 3'd0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty: cnt %0d rdy %b want 0 1", count, req_ready);
    end
    mult_valid_wb = 1'b1;
    mult_out = 16'h1234;
    step();
    mult_valid_wb = 1'b0;
    n_chk++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_discard: wb_valid %b want 0", wb_valid);
    end
    step();
    n_chk++;
    if (wb_valid !== 1'b0 || mult_en !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_idle: v %b en %b cnt %0d want 0 0 0",
               wb_valid, mult_en, count);
    end
    push_req(16'd7, 16'd9, 6'd9);
    serve_op(16'd63, seen, o1, o2, cnt, en2, wv, wd, wt);
    n_chk++;
    if (seen !== 1'b1 || o1 !== 16'd7 || o2 !== 16'd9 || wv !== 1'b1
        || wt !== 6'd9 || wd !== 16'd63) begin
      n_fail++;
      $display("FAIL after_flush: seen %b op %0d/%0d v %b t %0d d %0d",
               seen, o1, o2, wv, wt, wd);
    end
  endtask

  task automatic test_reset_wait();
    push_req(16'd2, 16'd3, 6'd30);
    push_req(16'd4, 16'd5, 6'd31);
    push_req(16'd6, 16'd7, 6'd32);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if ({mult_en, wb_valid, req_ready, count} !== {1'b0, 1'b0, 1'b1, 3'd0}
        || {mult_op1, mult_op2, wb_data, wb_tag} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait: en %b v %b rdy %b cnt %0d op %h/%h d %h t %h",
               mult_en, wb_valid, req_ready, count,
               mult_op1, mult_op2, wb_data, wb_tag);
    end
    mult_valid_wb = 1'b1;
    mult_out = 16'h00ff;
    step();
    mult_valid_wb = 1'b0;
    n_chk++;
    if (wb_valid !== 1'b0 || wb_data !== 16'd0 || mult_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray: v %b d %h en %b want 0 0 0",
               wb_valid, wb_data, mult_en);
    end
  endtask

  task automatic test_zero_result();
    logic seen, en2, wv;
    logic [15:0] o1, o2, wd;
    logic [5:0] wt;
    logic [2:0] cnt;
    push_req(16'h0100, 16'h0100, 6'd1);
    serve_op(16'h0000, seen, o1, o2, cnt, en2, wv, wd, wt);
    n_chk++;
    if (seen !== 1'b1 || o1 !== 16'h0100 || o2 !== 16'h0100 || wv !== 1'b1
        || wd !== 16'h0000 || wt !== 6'd1) begin
      n_fail++;
      $display("FAIL zero: seen %b op %h/%h v %b d %h t %0d",
               seen, o1, o2, wv, wd, wt);
    end
  endtask

  task automatic test_wrap();
    logic seen, en2, wv;
    logic [15:0] o1, o2, wd;
    logic [5:0] wt;
    logic [2:0] cnt;
    int bad = 0;
    for (int k = 0; k < 5; k++) begin
      push_req(16'(2 * k + 1), 16'(2 * k + 100), 6'(40 + 2 * k));
      push_req(16'(2 * k + 2), 16'(2 * k + 101), 6'(41 + 2 * k));
      if (count > 3'd4) bad++;
      for (int j = 0; j < 2; j++) begin
        int i = 2 * k + j;
        serve_op(16'((i + 1) * (i + 100)), seen, o1, o2, cnt, en2, wv, wd, wt);
        if (cnt > 3'd4) bad++;
        n_chk++;
        if (seen !== 1'b1 || o1 !== 16'(i + 1) || wv !== 1'b1
            || wt !== 6'(40 + i) || wd !== 16'((i + 1) * (i + 100))) begin
          n_fail++;
          $display("FAIL wrap%0d: seen %b op1 %0d v %b t %0d d %0d want %0d %0d",
                   i, seen, o1, wv, wt, wd, 40 + i, (i + 1) * (i + 100));
        end
      end
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL wrap_count: over-depth samples %0d want 0", bad);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op1 = '0;
    req_op2 = '0;
    req_tag = '0;
    flush = 1'b0;
    mult_free = 1'b0;
    mult_valid_wb = 1'b0;
    mult_out = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_reset_wait();
    test_zero_result();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
